// File: rtl/rtc_pkg.sv
// rtc_pkg: shared definitions for the RTC burst sequencer.
//   Control and Status3bit codes, RTC register index constants,
//   burst address lists with their lengths, and the FSM state encoding.
package rtc_pkg;

    typedef enum logic [2:0] {
        ST_INICIO,
        ST_INIT,
        ST_ESPERA,
        ST_LECT,
        ST_PROG,
        ST_ERROR
    } estado_t;

    localparam logic [1:0] CTRL_IDLE = 2'b00;
    localparam logic [1:0] CTRL_ESC  = 2'b01;
    localparam logic [1:0] CTRL_LEC  = 2'b10;

    localparam logic [2:0] STS_IDLE  = 3'b000;
    localparam logic [2:0] STS_INIT  = 3'b001;
    localparam logic [2:0] STS_LECT  = 3'b010;
    localparam logic [2:0] STS_PROG  = 3'b101;
    localparam logic [2:0] STS_ERROR = 3'b111;

    localparam logic [3:0] REG_NULO = 4'h0;
    localparam logic [3:0] REG_FIN  = 4'hF;

    // Lists are packed with entry 0 in the least significant nibble.
    localparam logic [3:0]  LEN_ESC   = 4'd11;
    localparam logic [43:0] LISTA_ESC = {REG_FIN, 4'hB, 4'hA, 4'h9, 4'h8, 4'h7,
                                         4'h6, 4'h5, 4'h4, 4'h3, 4'h2};
    localparam logic [3:0]  LEN_LEC   = 4'd8;
    localparam logic [31:0] LISTA_LEC = {REG_FIN, 4'h9, 4'h8, 4'h7, 4'h6, 4'h5,
                                         4'h4, 4'h3};

    function automatic logic [1:0] control_de(input estado_t e);
        case (e)
            ST_INIT, ST_PROG: return CTRL_ESC;
            ST_LECT:          return CTRL_LEC;
            default:          return CTRL_IDLE;
        endcase
    endfunction

    function automatic logic [2:0] status_de(input estado_t e);
        case (e)
            ST_INIT:  return STS_INIT;
            ST_LECT:  return STS_LECT;
            ST_PROG:  return STS_PROG;
            ST_ERROR: return STS_ERROR;
            default:  return STS_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/secuenciador_rtc_if.sv
// secuenciador_rtc_if: bundle between the burst sequencer and the RTC
// bus-signal generator.
//   master (sequencer): reads cont_32, enable_cont_32, programar;
//                       drives Control, sync, Selec_Mux_DDw, Status3bit, ocupado, error_to.
//   slave  (generator / user side): the mirror image.
interface secuenciador_rtc_if;
    logic [4:0] cont_32;
    logic       enable_cont_32;
    logic       programar;
    logic [1:0] Control;
    logic       sync;
    logic [3:0] Selec_Mux_DDw;
    logic [2:0] Status3bit;
    logic       ocupado;
    logic       error_to;

    modport master (
        input  cont_32, enable_cont_32, programar,
        output Control, sync, Selec_Mux_DDw, Status3bit, ocupado, error_to
    );

    modport slave (
        output cont_32, enable_cont_32, programar,
        input  Control, sync, Selec_Mux_DDw, Status3bit, ocupado, error_to
    );
endinterface

// File: rtl/rtc_lista_dir.sv
// rtc_lista_dir: combinational list ROM.
//   escritura in  1  1 = write list (INIT / PROG), 0 = read list (LECT)
//   paso      in  4  step index inside the list
//   indice    out 4  RTC register index for that step (0 when out of range)
//   valido    out 1  step lies inside the list
module rtc_lista_dir
    import rtc_pkg::*;
(
    input  logic       escritura,
    input  logic [3:0] paso,
    output logic [3:0] indice,
    output logic       valido
);

    always_comb begin
        indice = REG_NULO;
        valido = 1'b0;
        if (escritura) begin
            if (paso < LEN_ESC) begin
                valido = 1'b1;
                indice = LISTA_ESC[{paso, 2'b00} +: 4];
            end
        end else begin
            if (paso < LEN_LEC) begin
                valido = 1'b1;
                indice = LISTA_LEC[{paso[2:0], 2'b00} +: 4];
            end
        end
    end

endmodule

// File: rtl/secuenciador_rtc.sv
// secuenciador_rtc: chooses which RTC burst runs (init write, periodic read,
// user program write) and steps one register address per completed
// 32-clock bus transaction.
//   reloj   in  system clock, rising edge
//   resetM  in  synchronous active-high reset
//   bus     secuenciador_rtc_if.master (cont_32, enable_cont_32, programar in;
//           Control, sync, Selec_Mux_DDw, Status3bit, ocupado, error_to out)
// Optional build macro RTC_TIMEOUT_EN: per-transaction timeout that aborts the
// burst with Status3bit=111 and an error_to pulse. Without it error_to stays 0.
//
// state      | meaning
// ST_INICIO  | post-reset idle, counting ESPERA_INI clocks
// ST_INIT    | init write burst
// ST_ESPERA  | idle between bursts, serving pending requests
// ST_LECT    | periodic read burst
// ST_PROG    | user program write burst
// ST_ERROR   | one clock after a transaction timeout
module secuenciador_rtc
    import rtc_pkg::*;
#(
    parameter int ESPERA_INI  = 100,
    parameter int PERIODO_LEC = 2000,
    parameter int SYNC_CICLOS = 2,
    parameter int TIMEOUT     = 64
) (
    input  logic                  reloj,
    input  logic                  resetM,
    secuenciador_rtc_if.master    bus
);

    localparam int W_INI  = $clog2(ESPERA_INI + 1);
    localparam int W_PER  = $clog2(PERIODO_LEC + 1);
    localparam int W_SYNC = $clog2(SYNC_CICLOS + 1);

    estado_t           estado;
    estado_t           destino;
    logic [W_INI-1:0]  cnt_ini;
    logic [W_PER-1:0]  cnt_per;
    logic [W_SYNC-1:0] cnt_sync;
    logic              per_activo;
    logic              pend_prog;
    logic              pend_lect;
    logic [3:0]        paso_q;
    logic [1:0]        control_q;
    logic [2:0]        status_q;
    logic [3:0]        selec_q;
    logic              sync_q;
    logic              ocupado_q;
    logic              error_to_q;
`ifdef RTC_TIMEOUT_EN
    localparam int W_TO = $clog2(TIMEOUT + 1);
    logic [W_TO-1:0]   cnt_to;
`endif

    logic       fin_trans;
    logic       en_rafaga;
    logic       entrar;
    logic       escritura_rom;
    logic [3:0] paso_rom;
    logic [3:0] indice_sig;
    logic       valido_sig;

    assign fin_trans = bus.enable_cont_32 && (bus.cont_32 == 5'd31);
    assign en_rafaga = (estado == ST_INIT) || (estado == ST_LECT) || (estado == ST_PROG);
    assign entrar    = ((estado == ST_INICIO) && (cnt_ini == '0)) ||
                       ((estado == ST_ESPERA) && (pend_prog || pend_lect));

    // One ROM port serves both the first entry of the burst about to start
    // and the next entry of the burst in progress.
    always_comb begin
        destino       = ST_LECT;
        escritura_rom = 1'b0;
        paso_rom      = 4'd0;
        if (estado == ST_INICIO)
            destino = ST_INIT;
        else if (pend_prog)
            destino = ST_PROG;
        if (en_rafaga) begin
            escritura_rom = (estado != ST_LECT);
            paso_rom      = paso_q + 4'd1;
        end else begin
            escritura_rom = (destino != ST_LECT);
        end
    end

    rtc_lista_dir u_lista (
        .escritura (escritura_rom),
        .paso      (paso_rom),
        .indice    (indice_sig),
        .valido    (valido_sig)
    );

    always_ff @(posedge reloj) begin
        if (resetM) begin
            estado     <= ST_INICIO;
            cnt_ini    <= W_INI'(ESPERA_INI - 1);
            cnt_per    <= '0;
            cnt_sync   <= '0;
            per_activo <= 1'b0;
            pend_prog  <= 1'b0;
            pend_lect  <= 1'b0;
            paso_q     <= 4'd0;
            control_q  <= CTRL_IDLE;
            status_q   <= STS_IDLE;
            selec_q    <= REG_NULO;
            sync_q     <= 1'b0;
            ocupado_q  <= 1'b0;
            error_to_q <= 1'b0;
`ifdef RTC_TIMEOUT_EN
            cnt_to     <= '0;
`endif
        end else begin
            error_to_q <= 1'b0;

            if (sync_q) begin
                if (cnt_sync == '0)
                    sync_q <= 1'b0;
                else
                    cnt_sync <= cnt_sync - W_SYNC'(1);
            end

            // Clear-on-accept comes first so a request arriving on the same
            // clock survives as a new pending request.
            if (entrar && (destino == ST_PROG))
                pend_prog <= 1'b0;
            if (bus.programar)
                pend_prog <= 1'b1;
            if (entrar && (destino == ST_LECT))
                pend_lect <= 1'b0;

            if (per_activo) begin
                if (cnt_per == '0) begin
                    cnt_per   <= W_PER'(PERIODO_LEC - 1);
                    pend_lect <= 1'b1;
                end else begin
                    cnt_per <= cnt_per - W_PER'(1);
                end
            end

            if (entrar) begin
                estado    <= destino;
                control_q <= control_de(destino);
                status_q  <= status_de(destino);
                selec_q   <= indice_sig;
                paso_q    <= 4'd0;
                ocupado_q <= 1'b1;
                sync_q    <= 1'b1;
                cnt_sync  <= W_SYNC'(SYNC_CICLOS - 1);
`ifdef RTC_TIMEOUT_EN
                cnt_to    <= W_TO'(TIMEOUT - 1);
`endif
            end else begin
                case (estado)
                    ST_INICIO: cnt_ini <= cnt_ini - W_INI'(1);
                    ST_INIT, ST_LECT, ST_PROG: begin
                        if (fin_trans) begin
`ifdef RTC_TIMEOUT_EN
                            cnt_to <= W_TO'(TIMEOUT - 1);
`endif
                            if (valido_sig) begin
                                paso_q  <= paso_rom;
                                selec_q <= indice_sig;
                            end else begin
                                estado    <= ST_ESPERA;
                                control_q <= CTRL_IDLE;
                                status_q  <= STS_IDLE;
                                selec_q   <= REG_NULO;
                                ocupado_q <= 1'b0;
                                paso_q    <= 4'd0;
                                // The read period is measured from the end of init.
                                if (estado == ST_INIT) begin
                                    per_activo <= 1'b1;
                                    cnt_per    <= W_PER'(PERIODO_LEC - 1);
                                end
                            end
                        end
`ifdef RTC_TIMEOUT_EN
                        else if (cnt_to == '0) begin
                            estado     <= ST_ERROR;
                            control_q  <= CTRL_IDLE;
                            status_q   <= STS_ERROR;
                            selec_q    <= REG_NULO;
                            ocupado_q  <= 1'b0;
                            sync_q     <= 1'b0;
                            paso_q     <= 4'd0;
                            error_to_q <= 1'b1;
                        end else begin
                            cnt_to <= cnt_to - W_TO'(1);
                        end
`endif
                    end
                    ST_ERROR: begin
                        status_q <= STS_IDLE;
                        estado   <= ST_ESPERA;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.Control       = control_q;
    assign bus.sync          = sync_q;
    assign bus.Selec_Mux_DDw = selec_q;
    assign bus.Status3bit    = status_q;
    assign bus.ocupado       = ocupado_q;
    assign bus.error_to      = error_to_q;

endmodule
